// File: rtl/rv32i_pkg.sv
// Shared RV32I memory-interface constants and the fetch FSM state type.
package rv32i_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    WARMUP,
    FETCH,
    FAULT
  } fetch_state_t;

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter that wraps silently at 2^WIDTH.
module perf_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives the memory read port and
// presents fetched words to decode through a valid/ready output slot.
module instr_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] mem_read_address,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_read_data,
  output logic        misaligned_fault,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         instr_valid_q, instr_valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         fault_q, fault_d;
  logic         slot_free;

  assign slot_free = !instr_valid_q || instr_ready;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fault_d       = fault_q;

    unique case (state_q)
      WARMUP, FETCH: begin
        if (redirect_valid) begin
          // Redirect squashes the slot and wins over any capture this edge.
          instr_valid_d = 1'b0;
          if (redirect_pc[1:0] != 2'b00) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            state_d    = FETCH;
            fetch_pc_d = redirect_pc;
          end
        end else if (state_q == WARMUP) begin
          // Memory read register still holds a pre-reset sample; skip it.
          state_d = FETCH;
        end else if (slot_free) begin
          instr_d       = mem_read_data;
          instr_pc_d    = fetch_pc_q;
          instr_valid_d = 1'b1;
          fetch_pc_d    = fetch_pc_q + 32'd4;
        end
      end
      FAULT: begin
        instr_valid_d = 1'b0;
      end
      default: begin
        state_d       = WARMUP;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= WARMUP;
      fetch_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fault_q       <= fault_d;
    end
  end

  perf_counter #(
    .WIDTH(32)
  ) u_fetch_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (instr_valid_q && instr_ready),
    .count(fetch_count)
  );

  perf_counter #(
    .WIDTH(32)
  ) u_stall_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (instr_valid_q && !instr_ready),
    .count(stall_count)
  );

  assign instr_valid      = instr_valid_q;
  assign instr            = instr_q;
  assign instr_pc         = instr_pc_q;
  assign mem_read_address = fetch_pc_q;
  assign mem_funct3       = FUNCT3_LW;
  assign misaligned_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small behavioural read-only memory
// (word i = 32'h1000_0000 + i over the first 1 KiB, zero elsewhere).
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] mem_read_address;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_read_data;
  logic        misaligned_fault;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  int n_pass;
  int n_total;

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_ready     (instr_ready),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .mem_read_address(mem_read_address),
    .mem_funct3      (mem_funct3),
    .mem_read_data   (mem_read_data),
    .misaligned_fault(misaligned_fault),
    .fetch_count     (fetch_count),
    .stall_count     (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr < 32'h0000_0400) return 32'h1000_0000 + {2'b00, addr[31:2]};
    return 32'h0;
  endfunction

  // Memory samples the address on negedge; data is stable by the next posedge.
  initial mem_read_data = 32'h0;
  always @(negedge clk) mem_read_data <= mem_word(mem_read_address);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_slot(input string tag, input logic [31:0] exp_instr,
                            input logic [31:0] exp_pc);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    check({tag, "_instr"}, instr, exp_instr);
    check({tag, "_pc"}, instr_pc, exp_pc);
  endtask

  initial begin
    n_pass         = 0;
    n_total        = 0;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b1;
    step();
    step();

    // Reset state
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_addr", mem_read_address, 32'h0);
    check("rst_funct3", {29'b0, mem_funct3}, 32'd2);
    check("rst_fault", {31'b0, misaligned_fault}, 32'd0);
    check("rst_fcount", fetch_count, 32'd0);
    check("rst_scount", stall_count, 32'd0);

    // 1: warm-up cycle, then one word per cycle
    reset = 1'b0;
    step();
    check("warmup_valid", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      step();
      check_slot("stream", 32'h1000_0000 + i, 32'(i * 4));
    end
    check("stream_fcount", fetch_count, 32'd8);
    check("stream_scount", stall_count, 32'd0);

    // 2: back-pressure holds the slot for 5 cycles
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_slot("stall_hold", 32'h1000_0008, 32'h20);
    end
    check("stall_scount", stall_count, 32'd5);
    check("stall_fcount", fetch_count, 32'd8);
    instr_ready = 1'b1;
    step();
    check_slot("stall_release", 32'h1000_0009, 32'h24);
    check("release_fcount", fetch_count, 32'd9);
    step();
    check_slot("after_release", 32'h1000_000A, 32'h28);

    // 3: redirect squashes, handshake on the same edge still counts
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    check("redir_squash", {31'b0, instr_valid}, 32'd0);
    check("redir_addr", mem_read_address, 32'h100);
    check("redir_fcount", fetch_count, 32'd11);
    step();
    check_slot("redir_target", 32'h1000_0040, 32'h100);

    // Back-to-back redirects: last one wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    check("b2b_squash", {31'b0, instr_valid}, 32'd0);
    step();
    check_slot("b2b_target", 32'h1000_0080, 32'h200);

    // 5: wrap from the top of the address space, unmapped word reads zero
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wrap_squash", {31'b0, instr_valid}, 32'd0);
    step();
    check_slot("wrap_top", 32'h0, 32'hFFFF_FFFC);
    step();
    check_slot("wrap_zero", 32'h1000_0000, 32'h0);
    check("wrap_addr", mem_read_address, 32'h4);

    // 4: misaligned redirect faults; later redirects are ignored
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    step();
    redirect_pc = 32'h0;
    check("fault_flag", {31'b0, misaligned_fault}, 32'd1);
    check("fault_valid", {31'b0, instr_valid}, 32'd0);
    check("fault_addr", mem_read_address, 32'h4);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fault_stay_valid", {31'b0, instr_valid}, 32'd0);
      check("fault_stay_addr", mem_read_address, 32'h4);
    end
    redirect_valid = 1'b0;
    step();
    check("fault_sticky", {31'b0, misaligned_fault}, 32'd1);

    // 6: async reset clears fault; restart after one warm-up cycle
    #2 reset = 1'b1;
    #1;
    check("areset_fault", {31'b0, misaligned_fault}, 32'd0);
    check("areset_addr", mem_read_address, 32'h0);
    step();
    reset = 1'b0;
    step();
    check("rewarm_valid", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_slot("restream", 32'h1000_0000 + i, 32'(i * 4));
    end
    instr_ready = 1'b0;
    step();
    step();
    check("pre_reset_scount", stall_count, 32'd2);
    check("pre_reset_fcount", fetch_count, 32'd2);

    // Reset asserted between edges mid-stream
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
    check("mid_rst_fcount", fetch_count, 32'd0);
    check("mid_rst_scount", stall_count, 32'd0);
    check("mid_rst_funct3", {29'b0, mem_funct3}, 32'd2);
    instr_ready = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("mid_warm_valid", {31'b0, instr_valid}, 32'd0);
    step();
    check_slot("mid_restart", 32'h1000_0000, 32'h0);
    check("final_funct3", {29'b0, mem_funct3}, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
